// File: rtl/clk_gen_pkg.sv
// Shared types for the configurable clock generator: FSM states, the
// period/high/phase configuration record and its legality rule.
package clk_gen_pkg;

  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    STOP
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } cfg_t;

  // A config is usable only if it yields both a high and a low interval and
  // the phase offset lands inside one period.
  function automatic logic cfg_legal(input cfg_t c);
    return (c.period >= CFG_W'(2)) &&
           (c.high >= CFG_W'(1)) &&
           (c.high < c.period) &&
           (c.phase < c.period);
  endfunction

endpackage

// File: rtl/clk_gen_wave.sv
// Period counter plus registered reference and phase-shifted decodes.
// Holds the active config; a load strobe replaces it on the same edge.
module clk_gen_wave
  import clk_gen_pkg::*;
#(
  parameter cfg_t DEF_CFG = '{period: CFG_W'(10), high: CFG_W'(5), phase: CFG_W'(0)}
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic start,
  input  logic load,
  input  cfg_t load_cfg,
  output logic wrap,
  output logic clk_out_ref,
  output logic clk_out_phase
);

  cfg_t             act;
  cfg_t             act_n;
  logic [CFG_W-1:0] cnt;
  logic [CFG_W-1:0] cnt_n;
  logic [CFG_W:0]   pcnt_sum;
  logic [CFG_W:0]   pcnt;
  logic             ref_n;
  logic             phase_n;

  assign wrap = (cnt == act.period - 1'b1);

  // Outputs decode the next count with the next config so that the
  // registered waveform always matches the count it is shown with.
  always_comb begin
    act_n = load ? load_cfg : act;

    if (!run || start || wrap) cnt_n = '0;
    else                       cnt_n = cnt + 1'b1;

    // Phase never exceeds period-1, so the sum stays positive and below 2P.
    pcnt_sum = {1'b0, cnt_n} + {1'b0, act_n.period} - {1'b0, act_n.phase};
    if (pcnt_sum >= {1'b0, act_n.period}) pcnt = pcnt_sum - {1'b0, act_n.period};
    else                                  pcnt = pcnt_sum;

    ref_n   = run && (cnt_n < act_n.high);
    phase_n = run && (pcnt < {1'b0, act_n.high});
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act           <= DEF_CFG;
      cnt           <= '0;
      clk_out_ref   <= 1'b0;
      clk_out_phase <= 1'b0;
    end else begin
      act           <= act_n;
      cnt           <= cnt_n;
      clk_out_ref   <= ref_n;
      clk_out_phase <= phase_n;
    end
  end

endmodule

// File: rtl/clk_gen_ctrl.sv
// Clock generator controller: run/stop FSM, config handshake and the
// pending config that is applied only at a period boundary.
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int CNT_W      = CFG_W,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5,
  parameter int DEF_PHASE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic             clk_out_ref,
  output logic             clk_out_phase,
  output logic             period_tick,
  output logic             running
);

  localparam cfg_t DEF_CFG = '{
    period: CFG_W'(DEF_PERIOD),
    high:   CFG_W'(DEF_HIGH),
    phase:  CFG_W'(DEF_PHASE)
  };

  state_e state;
  state_e state_n;
  cfg_t   cfg_in;
  cfg_t   pend;
  cfg_t   load_cfg;
  logic   accept;
  logic   legal;
  logic   pend_we;
  logic   load;
  logic   run;
  logic   start;
  logic   wrap;

  assign cfg_in    = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = cfg_legal(cfg_in);
  assign running   = (state != IDLE);
  assign period_tick = running && wrap;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_cfg = cfg_in;
    pend_we  = 1'b0;
    run      = 1'b1;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        run  = 1'b0;
        load = accept && legal;
        if (en) begin
          state_n = RUN;
          run     = 1'b1;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (accept && legal) begin
          pend_we = 1'b1;
          state_n = PEND;
        end else if (!en) begin
          state_n = STOP;
        end
      end
      PEND: begin
        if (wrap) begin
          load     = 1'b1;
          load_cfg = pend;
          state_n  = en ? RUN : STOP;
        end
      end
      STOP: begin
        if (en) begin
          state_n = RUN;
        end else if (wrap) begin
          state_n = IDLE;
          run     = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_n;
      cfg_err <= accept && !legal;
      if (pend_we) pend <= cfg_in;
    end
  end

  clk_gen_wave #(
    .DEF_CFG(DEF_CFG)
  ) u_wave (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .start        (start),
    .load         (load),
    .load_cfg     (load_cfg),
    .wrap         (wrap),
    .clk_out_ref  (clk_out_ref),
    .clk_out_phase(clk_out_phase)
  );

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Self-checking bench for clk_gen_ctrl: per-cycle comparison against a
// behavioural model, directed scenarios with literal patterns, then random.
module tb_clk_gen_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PEND = 2;
  localparam int S_STOP = 3;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [15:0] cfg_high;
  logic [15:0] cfg_phase;
  logic        cfg_err;
  logic        clk_out_ref;
  logic        clk_out_phase;
  logic        period_tick;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  int err_seen = 0;

  // Model state: spec-level mode, position in period, active and pending cfg.
  int m_st = S_IDLE;
  int m_cnt = 0;
  int m_p = 10, m_h = 5, m_f = 0;
  int q_p = 0, q_h = 0, q_f = 0;
  bit m_err = 0;

  clk_gen_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .cfg_phase    (cfg_phase),
    .cfg_err      (cfg_err),
    .clk_out_ref  (clk_out_ref),
    .clk_out_phase(clk_out_phase),
    .period_tick  (period_tick),
    .running      (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  p, h, f, nxt;
    bit  acc, ok, wrap;
    p = int'(cfg_period);
    h = int'(cfg_high);
    f = int'(cfg_phase);
    if (!rst_n) begin
      m_st = S_IDLE; m_cnt = 0; m_err = 0;
      m_p = 10; m_h = 5; m_f = 0;
      q_p = 0; q_h = 0; q_f = 0;
    end else begin
      acc   = cfg_valid && (m_st == S_IDLE || m_st == S_RUN);
      ok    = (p >= 2) && (h >= 1) && (h < p) && (f < p);
      m_err = acc && !ok;
      wrap  = (m_cnt == m_p - 1);
      nxt   = wrap ? 0 : m_cnt + 1;
      case (m_st)
        S_IDLE: begin
          if (acc && ok) begin m_p = p; m_h = h; m_f = f; end
          if (en) m_st = S_RUN;
          m_cnt = 0;
        end
        S_RUN: begin
          m_cnt = nxt;
          if (acc && ok) begin q_p = p; q_h = h; q_f = f; m_st = S_PEND; end
          else if (!en) m_st = S_STOP;
        end
        S_PEND: begin
          m_cnt = nxt;
          if (wrap) begin
            m_p = q_p; m_h = q_h; m_f = q_f;
            m_st = en ? S_RUN : S_STOP;
          end
        end
        default: begin
          m_cnt = nxt;
          if (en) m_st = S_RUN;
          else if (wrap) m_st = S_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    bit on;
    if (chk_en) begin
      on = (m_st != S_IDLE);
      check("ref",     clk_out_ref,   on && (m_cnt < m_h));
      check("phase",   clk_out_phase, on && (((m_cnt - m_f + m_p) % m_p) < m_h));
      check("tick",    period_tick,   on && (m_cnt == m_p - 1));
      check("running", running,       on);
      check("ready",   cfg_ready,     (m_st == S_IDLE) || (m_st == S_RUN));
      check("err",     cfg_err,       m_err);
      if (cfg_err) err_seen++;
    end
  end

  task automatic capture(output logic [15:0] r, output logic [15:0] ph, output logic [15:0] tk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r[i]  = clk_out_ref;
      ph[i] = clk_out_phase;
      tk[i] = period_tick;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (running && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check("wait_idle", running, 1'b0);
  endtask

  // Ends at posedge+2 of the cycle in which the model count equals c.
  task automatic align_cnt(input int c, input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk); #2; k++;
    end while (m_cnt != c && k < budget);
    check("align", m_cnt == c, 1'b1);
  endtask

  task automatic offer(input int p, input int h, input int f);
    cfg_valid  = 1'b1;
    cfg_period = 16'(p);
    cfg_high   = 16'(h);
    cfg_phase  = 16'(f);
  endtask

  initial begin
    logic [15:0] r, ph, tk;
    int k, base, zeros, p;
    rst_n = 0; en = 0; cfg_valid = 0;
    cfg_period = 0; cfg_high = 0; cfg_phase = 0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1; chk_en = 1;
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_ref", clk_out_ref, 1'b0);

    // Defaults 10/5/0.
    en = 1;
    @(posedge clk);
    capture(r, ph, tk);
    check("def_ref", r, 16'h7C1F);
    check("def_phase", ph, 16'h7C1F);
    check("def_tick", tk, 16'h0200);
    @(posedge clk); #2; en = 0;
    wait_idle(30);

    // Config {8,2,3} loaded in IDLE.
    @(posedge clk); #2; offer(8, 2, 3);
    @(posedge clk); #2; cfg_valid = 0; en = 1;
    @(posedge clk);
    capture(r, ph, tk);
    check("c823_ref", r, 16'h0303);
    check("c823_phase", ph, 16'h1818);
    check("c823_tick", tk, 16'h8080);
    @(posedge clk); #2; en = 0;
    wait_idle(30);

    // Config {6,3,0} offered at cnt=4 of a 10-cycle period.
    rst_n = 0;
    @(posedge clk); #2; rst_n = 1; en = 1;
    align_cnt(4, 40);
    offer(6, 3, 0);
    @(posedge clk); #1;
    check("pend_ready", cfg_ready, 1'b0);
    #1; cfg_valid = 0;
    #0 k = 0;
    while (!cfg_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("pend_len", k, 5);
    capture(r, ph, tk);
    check("c630_ref", r, 16'h71C7);
    check("c630_tick", tk, 16'h0820);

    // Illegal configs are consumed and flagged.
    base = err_seen;
    @(posedge clk); #2; offer(1, 1, 0);
    @(posedge clk); #2; cfg_valid = 0;
    @(posedge clk); #2; offer(10, 10, 0);
    @(posedge clk); #2; cfg_valid = 0;
    repeat (2) @(posedge clk);
    check("err_pulses", err_seen - base, 2);

    // en falls at cnt=2: period completes, then IDLE after 8 edges.
    @(posedge clk); #2; rst_n = 0;
    @(posedge clk); #2; rst_n = 1; en = 1;
    align_cnt(2, 40);
    en = 0;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (running && k < 20);
    check("stop_len", k, 8);

    // en re-raised at cnt=6 in STOP: no gap.
    @(posedge clk); #2; en = 1;
    align_cnt(2, 40);
    en = 0;
    align_cnt(6, 10);
    en = 1;
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!running) zeros++;
    end
    check("no_gap", zeros, 0);

    // Reset while PEND holds {4,1,0}, during the high phase.
    align_cnt(9, 20);
    offer(4, 1, 0);
    @(posedge clk); #2; cfg_valid = 0; rst_n = 0;
    @(posedge clk); #1;
    check("rst_pend_run", running, 1'b0);
    check("rst_pend_ref", clk_out_ref, 1'b0);
    check("rst_pend_ph", clk_out_phase, 1'b0);
    check("rst_pend_rdy", cfg_ready, 1'b1);
    #1; rst_n = 1;
    @(posedge clk);
    capture(r, ph, tk);
    check("restart_ref", r, 16'h7C1F);

    // Random traffic.
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 99) < 4) en = ~en;
      cfg_valid  = ($urandom_range(0, 9) == 0);
      p          = int'($urandom_range(0, 12));
      cfg_period = 16'(p);
      cfg_high   = 16'($urandom_range(0, p + 1));
      cfg_phase  = 16'($urandom_range(0, p));
      rst_n      = ($urandom_range(0, 599) != 0);
    end
    @(posedge clk); #2; rst_n = 1; cfg_valid = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gen_ctrl.md
Name: clk_gen_ctrl

Overview:
Synthesizable, cycle-based controller for the configurable clock generator. It produces a reference clock-enable waveform and a phase-shifted copy, both derived from a single system clock. Period, high time and phase offset are held in shadow registers. A valid/ready handshake loads new values, which take effect only at a period boundary, so neither output ever produces a runt pulse. It sits between the register/config block and the clock-distribution logic.

Parameters:
CNT_W, 16, width of the period, high and phase counters and fields
DEF_PERIOD, 10, period in clk cycles after reset; must be >= 2
DEF_HIGH, 5, high time in clk cycles after reset; 1..DEF_PERIOD-1
DEF_PHASE, 0, phase offset in clk cycles after reset; 0..DEF_PERIOD-1

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous reset, active-low
en  input  1  run request; level-sensitive
cfg_valid  input  1  config request valid
cfg_ready  output  1  controller can accept config this cycle
cfg_period  input  CNT_W  requested period (clk cycles)
cfg_high  input  CNT_W  requested high time (clk cycles)
cfg_phase  input  CNT_W  requested phase delay of clk_out_phase (clk cycles)
cfg_err  output  1  one-cycle pulse: the offered config was rejected
clk_out_ref  output  1  reference waveform, registered
clk_out_phase  output  1  waveform delayed by the active phase, registered
period_tick  output  1  one-cycle pulse on the last cycle of each period
running  output  1  high in RUN, PEND and STOP

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at an edge) forces the following:
  - state=IDLE, cnt=0;
  - active period/high/phase = DEF_*; pending registers cleared;
  - all outputs 0 except cfg_ready=1.
- Active config (P, H, Φ):
  - cnt counts 0..P-1, then wraps to 0.
  - clk_out_ref = (cnt < H).
  - pcnt = (cnt + P - Φ) mod P, computed at CNT_W+1 bits with no overflow.
  - clk_out_phase = (pcnt < H).
  - Both outputs are registered and updated on the same edge as cnt, so each equals its decode of the current cnt. No combinational path from any input to these outputs.
- Config is legal iff P >= 2, 1 <= H <= P-1 and Φ <= P-1.
  - An illegal config offered while cfg_ready=1 and cfg_valid=1 is consumed (handshake completes).
  - cfg_err pulses on the next cycle and the active config is unchanged.
- States:
  - IDLE: cnt=0, both outputs 0.
    - en=1 -> RUN; on the next edge cnt=0, clk_out_ref=1, and clk_out_phase = decode of pcnt with cnt=0.
    - A legal accepted config loads into the active registers at the same edge.
  - RUN: counting.
    - A legal config accepted -> PEND (stored in pending registers).
    - en=0 -> STOP.
  - PEND: cfg_ready=0.
    - At the edge where cnt==P-1, the pending config becomes active and cnt=0; then -> RUN, or -> STOP if en=0.
    - en=0 while in PEND still applies the config at the wrap, then goes to STOP.
  - STOP: keeps counting and finishes the current period.
    - At the cnt==P-1 edge -> IDLE, outputs 0.
    - en=1 again before the wrap -> RUN, no break in the waveform.
    - cfg_ready=0.
- cfg_ready=1 only in IDLE and RUN.
- period_tick=1 whenever the state is not IDLE and cnt==P-1.
- Simultaneous events:
  - cfg accept together with en falling in RUN -> PEND, config applied at the wrap, then STOP.
  - cfg accept together with en rising in IDLE -> the new config is used from the first cycle.
- Reset mid-operation: immediate return to reset values at the next edge; pending config is discarded.
- running=1 in RUN, PEND and STOP.

Decomposition:
- Package clk_gen_pkg:
  - state enum {IDLE, RUN, PEND, STOP};
  - a cfg struct {period, high, phase} of CNT_W-bit fields;
  - a function cfg_legal().
- Sub-module clk_gen_wave:
  - counter, wrap detection, ref/phase decode and output registers;
  - inputs: load strobe, active cfg and run/hold control.
- clk_gen_ctrl holds the FSM, the handshake and the shadow/pending registers.

Test Plan:
- Reset, en=1, defaults -> clk_out_ref is 5 high / 5 low repeating; clk_out_phase equals clk_out_ref; period_tick every 10 cycles.
- In IDLE, cfg {8,2,3}, then en=1 -> ref is high for cycles 0-1 of each 8; phase is high at cnt 3-4; cfg_err=0.
- In RUN at cnt=4 of P=10, cfg {6,3,0} -> cfg_ready drops and the current 10-cycle period completes unchanged. The next period is 6 cycles with 3 high, and cfg_ready returns to 1.
- Illegal cfg {1,1,0} and then {10,10,0} -> a cfg_err pulse for each, and the waveform is unchanged.
- en falls at cnt=2 of P=10 -> the outputs finish the period, go to 0 after the cnt=9 edge, and running=0. Repeat with en re-raised at cnt=6 -> continuous waveform with no gap.
- rst_n=0 asserted mid-high phase while PEND holds a config -> the next cycle has all outputs 0 and IDLE. On restart the waveform uses the DEF_* values, not the discarded pending config.
